// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 status, icode, register and writeback state constants
package y86_pkg;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_t;

    function automatic logic is_stop_stat(input logic [2:0] stat);
        return (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction

endpackage

// File: rtl/writeback_stage_regfile.sv
// rtl/writeback_stage_regfile.sv - program register file, two async reads, E/M writes
module writeback_stage_regfile
    import y86_pkg::*;
#(
    parameter int NREGS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b,
    input  logic        we,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    logic [63:0] regs [NREGS];

    assign rval_a = (int'(src_a) < NREGS) ? regs[src_a] : 64'd0;
    assign rval_b = (int'(src_b) < NREGS) ? regs[src_b] : 64'd0;

    // M write is issued last so it overrides E on a shared destination (popq %rsp)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (we) begin
            if (dst_e != RNONE && int'(dst_e) < NREGS) begin
                regs[dst_e] <= val_e;
            end
            if (dst_m != RNONE && int'(dst_m) < NREGS) begin
                regs[dst_m] <= val_m;
            end
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - Y86-64 writeback: W register, regfile, halt control, retire count
module writeback_stage
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [63:0]      m_valE,
    input  logic [63:0]      m_valM,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic             w_stall,
    input  logic             w_bubble,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [2:0]       w_stat,
    output logic [3:0]       w_icode,
    output logic [63:0]      w_valE,
    output logic [63:0]      w_valM,
    output logic [3:0]       w_dstE,
    output logic [3:0]       w_dstM,
    output logic             halted,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] retired
);

    wb_state_t state;
    logic      reg_we;

    assign reg_we = (state == ST_RUN) && (w_stat == SAOK);

    writeback_stage_regfile #(.NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .src_a  (d_srcA),
        .src_b  (d_srcB),
        .rval_a (d_rvalA),
        .rval_b (d_rvalB),
        .we     (reg_we),
        .dst_e  (w_dstE),
        .val_e  (w_valE),
        .dst_m  (w_dstM),
        .val_m  (w_valM)
    );

    // Once HALTED, everything here freezes until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            halted     <= 1'b0;
            final_stat <= SAOK;
            retired    <= '0;
            w_stat     <= SBUB;
            w_icode    <= INOP;
            w_valE     <= 64'd0;
            w_valM     <= 64'd0;
            w_dstE     <= RNONE;
            w_dstM     <= RNONE;
        end else if (state == ST_RUN) begin
            if (w_stat == SAOK || w_stat == SHLT) begin
                retired <= retired + 1'b1;
            end
            if (is_stop_stat(w_stat)) begin
                state      <= ST_HALTED;
                halted     <= 1'b1;
                final_stat <= w_stat;
            end
            if (!w_stall) begin
                if (w_bubble) begin
                    w_stat  <= SBUB;
                    w_icode <= INOP;
                    w_valE  <= 64'd0;
                    w_valM  <= 64'd0;
                    w_dstE  <= RNONE;
                    w_dstM  <= RNONE;
                end else begin
                    w_stat  <= m_stat;
                    w_icode <= m_icode;
                    w_valE  <= m_valE;
                    w_valM  <= m_valM;
                    w_dstE  <= m_dstE;
                    w_dstM  <= m_dstM;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed and randomized bench for writeback_stage
module tb_writeback_stage;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  m_stat = SBUB;
    logic [3:0]  m_icode = INOP;
    logic [63:0] m_valE = '0;
    logic [63:0] m_valM = '0;
    logic [3:0]  m_dstE = RNONE;
    logic [3:0]  m_dstM = RNONE;
    logic        w_stall = 1'b0;
    logic        w_bubble = 1'b0;
    logic [3:0]  d_srcA = '0;
    logic [3:0]  d_srcB = '0;
    logic [63:0] d_rvalA, d_rvalB;
    logic [2:0]  w_stat;
    logic [3:0]  w_icode;
    logic [63:0] w_valE, w_valM;
    logic [3:0]  w_dstE, w_dstM;
    logic        halted;
    logic [2:0]  final_stat;
    logic [63:0] retired;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .w_stall(w_stall), .w_bubble(w_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .w_stat(w_stat), .w_icode(w_icode), .w_valE(w_valE), .w_valM(w_valM),
        .w_dstE(w_dstE), .w_dstM(w_dstM), .halted(halted), .final_stat(final_stat),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state of the final stage
    logic [63:0] mreg [15];
    logic [2:0]  ms;
    logic [3:0]  mi, mde, mdm;
    logic [63:0] mve, mvm;
    logic        mh;
    logic [2:0]  mf;
    logic [63:0] mr;

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mreg[i] = '0;
        ms = SBUB; mi = INOP; mve = '0; mvm = '0; mde = RNONE; mdm = RNONE;
        mh = 1'b0; mf = SAOK; mr = '0;
    endtask

    function automatic logic [63:0] model_read(input logic [3:0] a);
        return (a == 4'hF) ? 64'd0 : mreg[a];
    endfunction

    task automatic model_step();
        if (mh) return;
        if (ms == SAOK) begin
            if (mde != 4'hF) mreg[mde] = mve;
            if (mdm != 4'hF) mreg[mdm] = mvm;
        end
        if (ms == SAOK || ms == SHLT) mr = mr + 1;
        if (ms == SHLT || ms == SADR || ms == SINS) begin
            mh = 1'b1;
            mf = ms;
        end
        if (w_stall) begin
        end else if (w_bubble) begin
            ms = SBUB; mi = INOP; mve = '0; mvm = '0; mde = RNONE; mdm = RNONE;
        end else begin
            ms = m_stat; mi = m_icode; mve = m_valE; mvm = m_valM; mde = m_dstE; mdm = m_dstM;
        end
    endtask

    task automatic check_state(input string tag);
        logic [3:0] a, b;
        check({tag, ".w_stat"}, 64'(w_stat), 64'(ms));
        check({tag, ".w_icode"}, 64'(w_icode), 64'(mi));
        check({tag, ".w_valE"}, w_valE, mve);
        check({tag, ".w_valM"}, w_valM, mvm);
        check({tag, ".w_dstE"}, 64'(w_dstE), 64'(mde));
        check({tag, ".w_dstM"}, 64'(w_dstM), 64'(mdm));
        check({tag, ".halted"}, 64'(halted), 64'(mh));
        check({tag, ".final_stat"}, 64'(final_stat), 64'(mf));
        check({tag, ".retired"}, retired, mr);
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        d_srcA = a;
        d_srcB = b;
        #1;
        check({tag, ".rvalA"}, d_rvalA, model_read(a));
        check({tag, ".rvalB"}, d_rvalB, model_read(b));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            d_srcA = 4'(i);
            d_srcB = 4'(15 - i);
            #1;
            check($sformatf("%s.sweepA%0d", tag, i), d_rvalA, model_read(4'(i)));
            check($sformatf("%s.sweepB%0d", tag, 15 - i), d_rvalB, model_read(4'(15 - i)));
        end
    endtask

    task automatic set_in(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                          input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm,
                          input logic stall, input logic bubble);
        m_stat = st; m_icode = ic; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
        w_stall = stall; w_bubble = bubble;
    endtask

    task automatic idle();
        set_in(SBUB, INOP, RNONE, '0, RNONE, '0, 1'b0, 1'b0);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_a(input string tag, input logic [3:0] a, input logic [63:0] exp);
        d_srcA = a;
        #1;
        check(tag, d_rvalA, exp);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("warm");

        do_reset("rst");
        check("rst.w_icode_const", 64'(w_icode), 64'h1);
        check("rst.retired_const", retired, 64'd0);
        sweep("rst");

        // irmovq $0x1234, %rax
        set_in(SAOK, IIRMOVQ, 4'd0, 64'h1234, RNONE, '0, 1'b0, 1'b0);
        step("irm1");
        idle();
        step("irm2");
        read_a("irm.reg0", 4'd0, 64'h1234);
        check("irm.retired", retired, 64'd1);

        // popq %rsp: valM must win over valE
        set_in(SAOK, IPOPQ, 4'd4, 64'h100, 4'd4, 64'hABCD, 1'b0, 1'b0);
        step("pop1");
        idle();
        step("pop2");
        read_a("pop.reg4", 4'd4, 64'hABCD);

        // stall holds a retiring instruction in W for three edges
        set_in(SAOK, IIRMOVQ, 4'd5, 64'h55, RNONE, '0, 1'b0, 1'b0);
        step("stl0");
        set_in(SAOK, IIRMOVQ, 4'd6, 64'h66, RNONE, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("stall");
        check("stall.retired", retired, 64'd5);
        check("stall.dstE", 64'(w_dstE), 64'd5);
        set_in(SAOK, IIRMOVQ, 4'd6, 64'h66, RNONE, '0, 1'b0, 1'b1);
        step("bub1");
        step("bub2");
        check("bubble.stat", 64'(w_stat), 64'(SBUB));
        check("bubble.retired", retired, 64'd6);
        read_a("bubble.reg6", 4'd6, 64'd0);
        set_in(SAOK, IIRMOVQ, 4'd7, 64'h77, RNONE, '0, 1'b0, 1'b0);
        step("both0");
        set_in(SAOK, IIRMOVQ, 4'd8, 64'h88, RNONE, '0, 1'b1, 1'b1);
        step("both1");
        check("both.dstE", 64'(w_dstE), 64'd7);

        // halt, then later instructions are ignored
        set_in(SHLT, IHALT, RNONE, '0, RNONE, '0, 1'b0, 1'b0);
        step("hlt1");
        set_in(SAOK, IIRMOVQ, 4'd3, 64'd7, RNONE, '0, 1'b0, 1'b0);
        step("hlt2");
        check("hlt.halted", 64'(halted), 64'd1);
        check("hlt.final", 64'(final_stat), 64'(SHLT));
        step("hlt3");
        step("hlt4");
        read_a("hlt.reg3", 4'd3, 64'd0);

        // address exception: no write, not retired
        do_reset("rst2");
        set_in(SADR, IMRMOVQ, 4'd1, 64'd9, RNONE, '0, 1'b0, 1'b0);
        step("adr1");
        idle();
        step("adr2");
        check("adr.halted", 64'(halted), 64'd1);
        check("adr.final", 64'(final_stat), 64'(SADR));
        check("adr.retired", retired, 64'd0);
        read_a("adr.reg1", 4'd1, 64'd0);
        do_reset("rst3");
        sweep("rst3");

        // randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            do_reset("rnd_rst");
            for (int c = 0; c < 60; c++) begin
                int p;
                logic [2:0] st;
                p = int'($urandom_range(0, 99));
                if (p < 75) st = SAOK;
                else if (p < 94) st = SBUB;
                else if (p < 96) st = SHLT;
                else if (p < 98) st = SADR;
                else st = SINS;
                set_in(st, 4'($urandom_range(0, 11)),
                       ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14)),
                       {$urandom, $urandom},
                       ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : RNONE,
                       {$urandom, $urandom},
                       $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
                step("rnd");
            end
            sweep("rnd_end");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final Y86-64 pipeline stage. Contains the M->W pipeline register, the 15-entry 64-bit program register file, halt/exception control and a retired-instruction counter.
- Consumes valE/valM/dstE/dstM produced by the memory stage.
- Serves combinational register reads to decode.
- Exports the W-register contents for decode forwarding.

Parameters:
- NREGS, 15, number of program registers (%rax..%r14); index 4'hF = RNONE.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_stat  in  3  status from memory stage (SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4).
- m_icode  in  4  instruction code from memory stage.
- m_valE  in  64  ALU result.
- m_valM  in  64  memory read data (valM).
- m_dstE  in  4  destination for valE; 4'hF = none.
- m_dstM  in  4  destination for valM; 4'hF = none.
- w_stall  in  1  hold W register.
- w_bubble  in  1  load bubble into W register.
- d_srcA  in  4  decode read address A.
- d_srcB  in  4  decode read address B.
- d_rvalA  out  64  register file read data A (combinational).
- d_rvalB  out  64  register file read data B (combinational).
- w_stat  out  3  W register stat (forwarding/control).
- w_icode  out  4  W register icode.
- w_valE  out  64  W register valE.
- w_valM  out  64  W register valM.
- w_dstE  out  4  W register dstE.
- w_dstM  out  4  W register dstM.
- halted  out  1  registered; 1 once processor has stopped.
- final_stat  out  3  registered; stat that caused the stop, SAOK while running.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - W register = bubble: stat SBUB, icode 4'h1 (NOP), valE/valM 0, dstE/dstM 4'hF.
  - All 15 registers 0.
  - State RUN; halted 0; final_stat SAOK; retired 0.
- State machine has two states, RUN and HALTED. HALTED is left only by reset.
- W register update in RUN, at each edge:
  - w_stall=1: hold; stall wins over bubble when both are asserted.
  - else w_bubble=1: load the bubble values.
  - else: load the m_* inputs.
- Register writes in RUN: at each edge, writes use the W contents present before the edge.
  - Only performed when w_stat==SAOK.
  - dstE!=F: reg[dstE] <= valE.
  - dstM!=F: reg[dstM] <= valM.
  - dstE==dstM!=F: valM wins (popq %rsp semantics).
  - Index F is never written.
- Reads: d_rvalX = reg[d_srcX]; returns 0 when d_srcX==F. There is no internal write-to-read bypass. A write becomes visible on the cycle after its edge; decode forwarding covers the gap.
- Halt/exception in RUN, when w_stat is SHLT, SADR or SINS:
  - At the edge: no register write.
  - State -> HALTED; halted <= 1; final_stat <= w_stat.
- Retired counter in RUN: increments by 1 at an edge when w_stat is SAOK or SHLT.
  - SBUB, SADR and SINS are not counted.
  - Wraps modulo 2^CNT_W.
- In HALTED:
  - W register frozen, ignoring stall/bubble/m_* inputs.
  - No register writes; counter frozen.
  - Reads still functional.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk.
- Latency: an instruction's writes commit at the edge ending its single W cycle. halted rises one edge after the faulting instruction enters W.

Decomposition:
- y86_pkg holds:
  - stat constants SBUB/SAOK/SHLT/SADR/SINS (3-bit);
  - icode constants (INOP=1, IHALT=0, ...);
  - RNONE=4'hF;
  - run/halted state encoding.
- One sub-module, regfile: 15x64 array with 2 asynchronous read ports and 2 write ports (E, M), M-port priority, RNONE ignored.
- writeback_stage instantiates regfile and holds the W register, the FSM and the counter.

Test Plan:
- Reset: pulse rst_n low mid-cycle.
  - Response: w_icode=1, w_stat=0, w_dstE=F, halted=0, retired=0.
  - All 15 registers read 0 via d_srcA sweep.
- irmovq: m_stat=1, m_dstE=0, m_valE=0x1234 for one cycle, no stall.
  - Response: after the 2nd edge d_srcA=0 gives 0x1234; retired=1.
- popq %rsp: W holds dstE=4, valE=0x100, dstM=4, valM=0xABCD, stat SAOK.
  - Response: reg4=0xABCD after the edge.
- Stall/bubble:
  - w_stall=1 for 3 cycles with a valid write in W. Response: the same value is rewritten and retired increments by 3, since the instruction stays in W.
  - w_bubble=1. Response: stat SBUB, no write, counter unchanged.
  - Both asserted. Response: hold.
- Halt: m_stat=2 enters W.
  - Response: next edge halted=1, final_stat=2, retired +1.
  - Subsequent m_stat=1/dstE=3/valE=7 is ignored; reg3 stays unchanged.
- Exception: m_stat=3 (SADR) with dstE=1, valE=9.
  - Response: reg1 not written, halted=1, final_stat=3, retired unchanged.
  - Then rst_n low clears everything.
